// File: rtl/stopwatch_display_scan.sv
// Six-digit multiplexed 7-segment scanner for a stopwatch (MM:SS.hh).
// The digits are snapshotted once per full scan, so a digit can never change partway through being shown.
module stopwatch_display_scan #(
   parameter int unsigned REFRESH_DIV = 100000,
   parameter int unsigned GUARD       = 2000,
   parameter logic [5:0]  DP_MASK     = 6'b010100
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] digit5,
   input  logic [3:0] digit4,
   input  logic [3:0] digit3,
   input  logic [3:0] digit2,
   input  logic [3:0] digit1,
   input  logic [3:0] digit0,
   input  logic       blank_lead,
   output logic [5:0] an,
   output logic [6:0] seg,
   output logic       dp
);

   localparam int unsigned   CW      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

   typedef enum logic {S_GUARD, S_DRIVE} state_e;
   localparam state_e ST_RST = (GUARD > 0) ? S_GUARD : S_DRIVE;

   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      idx_q, idx_d;
   logic [5:0][3:0] snap_q, snap_d;
   state_e          state_q, state_d;
   logic [5:0]      an_q, an_d;
   logic [6:0]      seg_q, seg_d;
   logic            dp_q, dp_d;

   logic            cnt_wrap;
   logic [3:0]      cur;
   logic [5:0]      lead_blank;

   function automatic logic [6:0] decode(input logic [3:0] d);
      case (d)
         4'd0:    decode = 7'b1000000;
         4'd1:    decode = 7'b1111001;
         4'd2:    decode = 7'b0100100;
         4'd3:    decode = 7'b0110000;
         4'd4:    decode = 7'b0011001;
         4'd5:    decode = 7'b0010010;
         4'd6:    decode = 7'b0000010;
         4'd7:    decode = 7'b1111000;
         4'd8:    decode = 7'b0000000;
         4'd9:    decode = 7'b0010000;
         default: decode = 7'b1111111;
      endcase
   endfunction

   // State is a function of cnt_q; computing it from cnt_d keeps the two aligned.
   always_comb begin
      cnt_wrap = (cnt_q == CNT_MAX);
      cnt_d    = cnt_wrap ? '0 : cnt_q + 1'b1;
      idx_d    = idx_q;
      snap_d   = snap_q;
      if (cnt_wrap) begin
         if (idx_q == 3'd5) begin
            idx_d  = 3'd0;
            snap_d = {digit5, digit4, digit3, digit2, digit1, digit0};
         end else begin
            idx_d = idx_q + 3'd1;
         end
      end
      state_d = (32'(cnt_d) < GUARD) ? S_GUARD : S_DRIVE;
   end

   // Leading-zero suppression only reaches down to the seconds-tens digit.
   always_comb begin
      lead_blank    = '0;
      lead_blank[5] = blank_lead && (snap_q[5] == 4'd0);
      lead_blank[4] = lead_blank[5] && (snap_q[4] == 4'd0);
      lead_blank[3] = lead_blank[4] && (snap_q[3] == 4'd0);
   end

   always_comb begin
      cur  = snap_q[idx_q];
      an_d  = 6'b111111;
      seg_d = 7'b1111111;
      dp_d  = 1'b1;
      if (state_q == S_DRIVE) begin
         an_d[idx_q] = 1'b0;
         seg_d = lead_blank[idx_q] ? 7'b1111111 : decode(cur);
         dp_d  = ~(DP_MASK[idx_q] & ~lead_blank[idx_q]);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q   <= '0;
         idx_q   <= 3'd0;
         snap_q  <= '0;
         state_q <= ST_RST;
         an_q    <= 6'b111111;
         seg_q   <= 7'b1111111;
         dp_q    <= 1'b1;
      end else begin
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         snap_q  <= snap_d;
         state_q <= state_d;
         an_q    <= an_d;
         seg_q   <= seg_d;
         dp_q    <= dp_d;
      end
   end

   assign an  = an_q;
   assign seg = seg_q;
   assign dp  = dp_q;

endmodule

// File: tb/tb_stopwatch_display_scan.sv
// Randomized bench for stopwatch_display_scan against a cycle-count reference model.
module tb_stopwatch_display_scan;

   localparam int unsigned RD  = 4;
   localparam int unsigned GD  = 1;
   localparam logic [5:0]  DPM = 6'b010100;
   localparam logic [6:0]  SEGTAB [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] digit5 = '0, digit4 = '0, digit3 = '0, digit2 = '0, digit1 = '0, digit0 = '0;
   logic       blank_lead = 1'b0;
   logic [5:0] an;
   logic [6:0] seg;
   logic       dp;

   int n_cmp = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   int unsigned m;
   logic [23:0] msnap;
   logic [13:0] exp_o;

   stopwatch_display_scan #(.REFRESH_DIV(RD), .GUARD(GD), .DP_MASK(DPM)) dut (
      .clk(clk), .rst(rst),
      .digit5(digit5), .digit4(digit4), .digit3(digit3),
      .digit2(digit2), .digit1(digit1), .digit0(digit0),
      .blank_lead(blank_lead), .an(an), .seg(seg), .dp(dp)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      if (obs !== expv) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, expv, $time);
      end
   endtask

   // Display for the slot position mm edges after reset, from the scan rules alone.
   function automatic logic [13:0] model_fn(input int unsigned mm, input logic [23:0] s, input logic bl);
      int cnt, idx;
      logic [3:0] d;
      logic blank;
      logic [5:0] a;
      logic [6:0] sg;
      cnt = int'(mm % RD);
      idx = int'((mm / RD) % 6);
      if (cnt < int'(GD)) return {6'h3F, 7'h7F, 1'b1};
      d = s[4*idx +: 4];
      blank = 1'b0;
      if (bl && idx >= 3) begin
         blank = 1'b1;
         for (int k = 5; k >= idx; k--) if (s[4*k +: 4] != 4'd0) blank = 1'b0;
      end
      a = 6'h3F;
      a[idx] = 1'b0;
      sg = (blank || d > 4'd9) ? 7'h7F : SEGTAB[d];
      return {a, sg, ~(DPM[idx] & ~blank)};
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m     <= 0;
         msnap <= '0;
         exp_o <= {6'h3F, 7'h7F, 1'b1};
      end else begin
         exp_o <= model_fn(m, msnap, blank_lead);
         m     <= m + 1;
         if ((m + 1) % (RD * 6) == 0) msnap <= {digit5, digit4, digit3, digit2, digit1, digit0};
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("an", 32'(an), 32'(exp_o[13:8]));
         chk("seg", 32'(seg), 32'(exp_o[7:1]));
         chk("dp", 32'(dp), 32'(exp_o[0]));
         chk("onehot", 32'($countones(~an) <= 1), 32'd1);
      end
   end

   task automatic set_digits(input logic [3:0] d5, d4, d3, d2, d1, d0);
      digit5 = d5; digit4 = d4; digit3 = d3; digit2 = d2; digit1 = d1; digit0 = d0;
   endtask

   task automatic run(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_pos(input int unsigned pos, input string tag);
      int budget = 100;
      while ((m % (RD * 6)) != pos && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      chk({tag, "_timeout"}, 32'(budget > 0), 32'd1);
   endtask

   initial begin
      chk_en = 1'b1;
      // Reset held while clock runs
      run(5);
      @(negedge clk) rst = 1'b1;

      // Full scan 5,9,5,9,9,9 without blanking
      set_digits(4'd5, 4'd9, 4'd5, 4'd9, 4'd9, 4'd9);
      blank_lead = 1'b0;
      run(60);

      // Leading-zero blanking
      set_digits(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd7);
      blank_lead = 1'b1;
      run(50);

      // Inputs changing mid-scan must not tear the displayed frame
      wait_pos(9, "tear");
      set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
      run(3);
      set_digits(4'd3, 4'd0, 4'd4, 4'd1, 4'd8, 4'd2);
      run(50);

      // Invalid BCD code
      set_digits(4'd0, 4'd1, 4'd2, 4'd3, 4'hC, 4'd5);
      blank_lead = 1'b0;
      run(50);

      // Asynchronous reset at idx=3, cnt=2
      wait_pos(14, "midrst");
      #1 rst = 1'b0;
      #1;
      chk("rst_an", 32'(an), 32'h3F);
      chk("rst_seg", 32'(seg), 32'h7F);
      chk("rst_dp", 32'(dp), 32'd1);
      @(negedge clk) rst = 1'b1;
      run(30);

      // Random digits, random blanking, occasional reset
      for (int i = 0; i < 700; i++) begin
         @(negedge clk);
         if ($urandom_range(0, 9) == 0) begin
            set_digits(4'($urandom), 4'($urandom), 4'($urandom),
                       4'($urandom), 4'($urandom), 4'($urandom));
         end
         if ($urandom_range(0, 4) == 0) blank_lead = 1'($urandom);
         rst = ($urandom_range(0, 199) != 0);
      end
      @(negedge clk) rst = 1'b1;
      run(30);

      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
